// File: rtl/game_2048_pkg.sv
// game_2048_pkg: shared types and constants for the 2048 turn logic
package game_2048_pkg;
    localparam int TILE_W = 12;
    localparam logic [3:0] DIR_LEFT  = 4'b1000;
    localparam logic [3:0] DIR_DOWN  = 4'b0100;
    localparam logic [3:0] DIR_UP    = 4'b0010;
    localparam logic [3:0] DIR_RIGHT = 4'b0001;
    typedef enum logic [3:0] {
        BOOT, CLEAR, SCAN, WRITE, EVAL, IDLE, CHECK, REJECT, START, WAIT, WON, LOST
    } turn_state_t;
    // board[row][col] selects one tile
    typedef logic [3:0][3:0][TILE_W-1:0] board_t;
    function automatic logic is_onehot(input logic [3:0] d);
        return d != 4'd0 && (d & (d - 4'd1)) == 4'd0;
    endfunction
endpackage

// File: rtl/spawn_lfsr.sv
// spawn_lfsr: 16-bit Galois LFSR (x^16+x^14+x^13+x^11+1) picking spawn cells
module spawn_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [15:0] lfsr
);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)  lfsr <= SEED;
        else if (en) lfsr <= {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
endmodule

// File: rtl/game_turn_controller.sv
// game_turn_controller: sequences accept/check/move/spawn/evaluate for each 2048 turn
module game_turn_controller
    import game_2048_pkg::*;
#(
    parameter logic [TILE_W-1:0] WIN_VALUE = 12'd2048,
    parameter logic [15:0]       LFSR_SEED = 16'hACE1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              new_game,
    input  logic              dir_valid,
    input  logic [3:0]        dir_req,
    output logic              dir_ready,
    input  logic [3:0]        side_possible,
    input  board_t            board,
    output logic              board_clear,
    output logic              move_start,
    output logic [3:0]        move_dir,
    input  logic              move_done,
    output logic              move_rejected,
    output logic              spawn_we,
    output logic [1:0]        spawn_row,
    output logic [1:0]        spawn_col,
    output logic [TILE_W-1:0] spawn_value,
    output logic [15:0]       moves_count,
    output logic              game_won,
    output logic              game_lost,
    output logic              busy
);
    turn_state_t state, nxt;
    logic [15:0] lfsr;
    logic [3:0]  dir, idx, scan_cnt;
    logic [1:0]  spawns_left;
    logic        val4, win, cell_empty;

    spawn_lfsr #(.SEED(LFSR_SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .en(1'b1), .lfsr(lfsr));

    always_comb begin
        win = 1'b0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                win = win | (board[r][c] >= WIN_VALUE);
    end

    assign cell_empty = board[idx[3:2]][idx[1:0]] == '0;

    always_comb begin
        nxt = state;
        case (state)
            BOOT:    nxt = CLEAR;
            CLEAR:   nxt = SCAN;
            SCAN:    nxt = cell_empty ? WRITE : scan_cnt == 4'd15 ? EVAL : SCAN;
            WRITE:   nxt = spawns_left > 2'd1 ? SCAN : EVAL;
            EVAL:    nxt = win ? WON : side_possible == 4'd0 ? LOST : IDLE;
            IDLE:    nxt = dir_valid ? CHECK : IDLE;
            CHECK:   nxt = is_onehot(dir) && (dir & side_possible) != 4'd0 ? START : REJECT;
            REJECT:  nxt = IDLE;
            START:   nxt = WAIT;
            WAIT:    nxt = move_done ? SCAN : WAIT;
            default: nxt = state;
        endcase
        if (new_game && state != BOOT) nxt = CLEAR;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) state <= BOOT;
        else        state <= nxt;

    // every entry into SCAN restarts from a fresh pseudo-random cell
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            dir         <= '0;
            idx         <= '0;
            val4        <= 1'b0;
            scan_cnt    <= '0;
            spawns_left <= '0;
            moves_count <= '0;
        end else begin
            if (state == IDLE && nxt == CHECK) dir <= dir_req;
            if (nxt == SCAN && state != SCAN) begin
                idx      <= lfsr[3:0];
                val4     <= lfsr[7:4] == 4'd0;
                scan_cnt <= '0;
            end else if (state == SCAN && nxt == SCAN) begin
                idx      <= idx + 4'd1;
                scan_cnt <= scan_cnt + 4'd1;
            end
            if (state == CLEAR) begin
                moves_count <= '0;
                spawns_left <= 2'd2;
            end
            if (state == START) begin
                moves_count <= moves_count + {15'd0, moves_count != 16'hFFFF};
                spawns_left <= 2'd1;
            end
            if (state == WRITE) spawns_left <= spawns_left - 2'd1;
        end

    assign dir_ready     = state == IDLE;
    assign board_clear   = state == CLEAR;
    assign move_start    = state == START;
    assign move_rejected = state == REJECT;
    assign spawn_we      = state == WRITE;
    assign spawn_row     = idx[3:2];
    assign spawn_col     = idx[1:0];
    assign spawn_value   = spawn_we ? (val4 ? TILE_W'(4) : TILE_W'(2)) : '0;
    assign move_dir      = dir;
    assign game_won      = state == WON;
    assign game_lost     = state == LOST;
    assign busy          = !(state inside {BOOT, IDLE, WON, LOST});
endmodule

// File: tb/tb_game_turn_controller.sv
// tb_game_turn_controller: randomized turns against a board/move-engine model with rule-level expectations
module tb_game_turn_controller;
    import game_2048_pkg::*;

    logic        clk, rst_n, new_game, dir_valid, move_done;
    logic [3:0]  dir_req, side_possible, move_dir;
    board_t      board;
    logic        dir_ready, board_clear, move_start, move_rejected, spawn_we;
    logic [1:0]  spawn_row, spawn_col;
    logic [11:0] spawn_value;
    logic [15:0] moves_count;
    logic        game_won, game_lost, busy;

    game_turn_controller dut (
        .clk(clk), .rst_n(rst_n), .new_game(new_game), .dir_valid(dir_valid), .dir_req(dir_req),
        .dir_ready(dir_ready), .side_possible(side_possible), .board(board), .board_clear(board_clear),
        .move_start(move_start), .move_dir(move_dir), .move_done(move_done), .move_rejected(move_rejected),
        .spawn_we(spawn_we), .spawn_row(spawn_row), .spawn_col(spawn_col), .spawn_value(spawn_value),
        .moves_count(moves_count), .game_won(game_won), .game_lost(game_lost), .busy(busy)
    );

    logic [43:0] outs;
    assign outs = {board_clear, move_start, move_dir, move_rejected, spawn_we, spawn_row, spawn_col,
                   spawn_value, moves_count, game_won, game_lost, busy, dir_ready};

    logic [11:0] mb [16];
    logic [11:0] post_b [16];
    logic [3:0]  post_side;
    logic [15:0] exp_moves;
    int n_vec, n_err, ncyc, t_done, t0, eng, n_clear, n_spawn, n_start;

    always_comb
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                board[r][c] = mb[r*4+c];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // one clock: board register and move engine react to what the DUT shows this cycle
    task automatic cyc();
        int i;
        @(negedge clk);
        ncyc++;
        move_done = 1'b0;
        if (board_clear) begin
            n_clear++;
            for (int k = 0; k < 16; k++) mb[k] = '0;
        end
        if (spawn_we) begin
            i = int'(spawn_row) * 4 + int'(spawn_col);
            n_spawn++;
            chk("spawn_cell_empty", 64'(mb[i]), 64'd0);
            chk("spawn_value_2_or_4", 64'(spawn_value == 12'd2 || spawn_value == 12'd4), 64'd1);
            mb[i] = spawn_value;
        end
        if (move_start) begin
            n_start++;
            eng = 5;
        end else if (eng > 0) begin
            eng--;
            if (eng == 0) begin
                move_done = 1'b1;
                t_done = ncyc;
                for (int k = 0; k < 16; k++) mb[k] = post_b[k];
                side_possible = post_side;
            end
        end
    endtask

    task automatic await_end();
        for (int k = 0; k < 60 && !(dir_ready || game_won || game_lost); k++) cyc();
        chk("settle_timeout", 64'(dir_ready | game_won | game_lost), 64'd1);
    endtask

    task automatic boot_check();
        await_end();
        chk("boot_clears", 64'(n_clear), 64'd1);
        chk("boot_spawns", 64'(n_spawn), 64'd2);
        chk("boot_moves", 64'(moves_count), 64'd0);
        chk("boot_ready_busy_end", {60'd0, dir_ready, busy, game_won, game_lost}, 64'b1000);
        chk("boot_min_len", 64'((ncyc - t0) >= 7), 64'd1);
        exp_moves = '0;
    endtask

    task automatic turn(input logic [3:0] d, input logic [3:0] s);
        logic legal, won;
        int st0, ns0, empt;
        chk("turn_ready", 64'(dir_ready), 64'd1);
        side_possible = s;
        dir_req = d;
        dir_valid = 1'b1;
        st0 = n_start;
        cyc();
        dir_valid = 1'b0;
        chk("check_busy_ready", {62'd0, busy, dir_ready}, 64'b10);
        cyc();
        legal = $countones(d) == 1 && (d & s) != 4'd0;
        chk("start_at_t2", 64'(move_start), 64'(legal));
        chk("reject_at_t2", 64'(move_rejected), 64'(!legal));
        if (!legal) begin
            cyc();
            chk("reject_back_idle", 64'(dir_ready), 64'd1);
            chk("reject_moves", 64'(moves_count), 64'(exp_moves));
            chk("reject_no_start", 64'(n_start - st0), 64'd0);
            return;
        end
        chk("move_dir", 64'(move_dir), 64'(d));
        exp_moves = exp_moves == 16'hFFFF ? exp_moves : exp_moves + 16'd1;
        empt = 0;
        for (int k = 0; k < 16; k++) if (post_b[k] == '0) empt++;
        ns0 = n_spawn;
        await_end();
        won = 1'b0;
        for (int k = 0; k < 16; k++) if (mb[k] >= 12'd2048) won = 1'b1;
        chk("turn_spawns", 64'(n_spawn - ns0), 64'(empt > 0));
        chk("turn_moves", 64'(moves_count), 64'(exp_moves));
        chk("turn_won", 64'(game_won), 64'(won));
        chk("turn_lost", 64'(game_lost), 64'(!won && post_side == 4'd0));
        chk("turn_ready_end", 64'(dir_ready), 64'(!won && post_side != 4'd0));
        chk("move_dir_hold", 64'(move_dir), 64'(d));
    endtask

    task automatic finish_game();
        logic [1:0] held;
        int st0;
        held = {game_won, game_lost};
        side_possible = 4'b1111;
        dir_req = DIR_LEFT;
        dir_valid = 1'b1;
        st0 = n_start;
        repeat (3) cyc();
        dir_valid = 1'b0;
        chk("end_ignores_dir", 64'(n_start - st0), 64'd0);
        chk("end_holds", {61'd0, game_won, game_lost, dir_ready}, {61'd0, held, 1'b0});
        n_clear = 0;
        n_spawn = 0;
        t0 = ncyc;
        new_game = 1'b1;
        cyc();
        new_game = 1'b0;
        chk("new_game_clear", 64'(board_clear), 64'd1);
        boot_check();
    endtask

    task automatic rnd_post();
        for (int k = 0; k < 16; k++)
            post_b[k] = $urandom_range(0, 2) == 0 ? 12'd0 : 12'(1 << $urandom_range(1, 10));
        case ($urandom_range(0, 7))
            0: post_b[$urandom_range(0, 15)] = 12'd2048;
            1: post_b[$urandom_range(0, 15)] = 12'd2047;
            2: post_b[$urandom_range(0, 15)] = 12'd4095;
            3: for (int k = 0; k < 16; k++) if (post_b[k] == '0) post_b[k] = 12'd2;
            default: ;
        endcase
        post_side = $urandom_range(0, 3) == 0 ? 4'd0 : 4'($urandom_range(1, 15));
    endtask

    initial begin
        n_vec = 0; n_err = 0; ncyc = 0; eng = 0; n_start = 0; exp_moves = '0;
        rst_n = 1'b0; new_game = 1'b0; dir_valid = 1'b0; dir_req = '0; move_done = 1'b0;
        side_possible = 4'b1111; post_side = 4'b1111;
        for (int k = 0; k < 16; k++) begin mb[k] = '0; post_b[k] = '0; end
        #1 chk("reset_outputs", 64'(outs), 64'd0);
        repeat (2) @(negedge clk);
        n_clear = 0; n_spawn = 0; t0 = ncyc;
        rst_n = 1'b1;
        boot_check();

        turn(4'b0001, 4'b1000);
        turn(4'b1100, 4'b1000);
        turn(4'b0000, 4'b1111);

        for (int k = 0; k < 16; k++) post_b[k] = mb[k];
        post_side = 4'b1111;
        turn(DIR_LEFT, 4'b1000);
        chk("first_move_count", 64'(moves_count), 64'd1);

        for (int k = 0; k < 16; k++) post_b[k] = mb[k];
        post_b[5] = 12'd2048;
        turn(DIR_LEFT, 4'b1000);
        chk("win_reached", 64'(game_won), 64'd1);
        finish_game();

        for (int k = 0; k < 16; k++) post_b[k] = 12'd2;
        post_b[9] = 12'd1024;
        post_side = 4'd0;
        turn(DIR_UP, 4'b0010);
        chk("full_scan_latency", 64'(ncyc - t_done), 64'd18);
        chk("lost_reached", 64'(game_lost), 64'd1);
        finish_game();

        side_possible = 4'b1000;
        dir_req = DIR_LEFT;
        dir_valid = 1'b1;
        cyc();
        dir_valid = 1'b0;
        repeat (2) cyc();
        #2 rst_n = 1'b0;
        #1 chk("async_reset_outputs", 64'(outs), 64'd0);
        @(negedge clk);
        eng = 0; move_done = 1'b0; side_possible = 4'b1111;
        n_clear = 0; n_spawn = 0; t0 = ncyc;
        rst_n = 1'b1;
        boot_check();

        for (int t = 0; t < 40; t++) begin
            logic [3:0] d, s;
            d = $urandom_range(0, 1) ? 4'(1 << $urandom_range(0, 3)) : 4'($urandom_range(0, 15));
            s = 4'($urandom_range(0, 15));
            rnd_post();
            turn(d, s);
            if (game_won || game_lost) finish_game();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
